// File: rtl/serv_state_w.sv
// Phase sequencer for a W-bit-per-beat serial core: beat counter, two-stage
// INIT/RUN flow, and the ibus/dbus/RF/MDU handshakes.
module serv_state_w #(
    parameter int W              = 1,
    parameter     RESET_STRATEGY = "MINI",
    parameter bit WITH_CSR       = 1'b1,
    parameter bit MDU            = 1'b0,
    parameter bit STALL          = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_new_irq,
    input  logic       i_alu_cmp,
    input  logic       i_stall,
    input  logic       i_two_stage_op,
    input  logic       i_branch_op,
    input  logic       i_cond_branch,
    input  logic       i_bne_or_bge,
    input  logic       i_dbus_en,
    input  logic       i_shift_op,
    input  logic       i_sh_right,
    input  logic       i_sh_done,
    input  logic       i_slt_or_branch,
    input  logic       i_e_op,
    input  logic       i_rd_op,
    input  logic       i_mdu_op,
    input  logic       i_ctrl_misalign,
    input  logic       i_mem_misalign,
    input  logic       i_mdu_ready,
    input  logic       i_dbus_ack,
    input  logic       i_ibus_ack,
    input  logic       i_rf_ready,
    output logic       o_init,
    output logic       o_cnt_en,
    output logic [4:0] o_cnt,
    output logic       o_cnt0,
    output logic       o_cnt0to3,
    output logic       o_cnt12to31,
    output logic       o_cnt_done,
    output logic       o_ctrl_pc_en,
    output logic       o_ctrl_jump,
    output logic       o_ctrl_trap,
    output logic       o_mdu_valid,
    output logic       o_dbus_cyc,
    output logic       o_ibus_cyc,
    output logic       o_rf_rreq,
    output logic       o_rf_wreq,
    output logic       o_rf_rd_en
);

    localparam int N  = 32 / W;
    localparam int IW = $clog2(N);
    localparam int SH = $clog2(W);
    localparam bit RST_ALL = (RESET_STRATEGY != "NONE");

    logic [IW-1:0] idx_q, idx_d;
    logic          cnt_en_q, cnt_en_d;
    logic          init_done_q, init_done_d;
    logic          jump_q, jump_d;
    logic          misalign_q, misalign_d;
    logic          stage_two_req_q, stage_two_req_d;
    logic          ibus_cyc_q, ibus_cyc_d;

    logic          stall_eff;
    logic          cnt_done;
    logic          take_branch;
    logic          trap_pending;
    logic [4:0]    cnt;

    assign stall_eff    = STALL & i_stall;
    // Gating with i_rst keeps a reset landing on the last beat from pulsing done.
    assign cnt_done     = cnt_en_q & (idx_q == IW'(N - 1)) & ~stall_eff & ~i_rst;
    assign cnt          = 5'(idx_q) << SH;
    assign take_branch  = i_branch_op & (~i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
    assign trap_pending = (take_branch & i_ctrl_misalign) | (i_dbus_en & i_mem_misalign);

    assign o_init       = i_two_stage_op & ~i_new_irq & ~init_done_q;
    assign o_cnt_en     = cnt_en_q;
    assign o_cnt        = cnt;
    assign o_cnt0       = cnt_en_q & (idx_q == '0);
    assign o_cnt0to3    = cnt_en_q & (cnt < 5'd4);
    assign o_cnt12to31  = cnt_en_q & (cnt >= 5'd12);
    assign o_cnt_done   = cnt_done;
    assign o_ctrl_pc_en = cnt_en_q & ~o_init;
    assign o_ctrl_jump  = jump_q;
    assign o_ctrl_trap  = WITH_CSR & (i_e_op | i_new_irq | misalign_q);
    assign o_rf_rreq    = i_ibus_ack | (stage_two_req_q & misalign_q);
    assign o_rf_wreq    = ~misalign_q & ~cnt_en_q & init_done_q &
                          ((i_shift_op & (i_sh_done | ~i_sh_right)) | i_dbus_ack |
                           (MDU & i_mdu_ready) | i_slt_or_branch);
    assign o_dbus_cyc   = ~cnt_en_q & init_done_q & i_dbus_en & ~i_mem_misalign;
    assign o_mdu_valid  = MDU & ~cnt_en_q & init_done_q & i_mdu_op;
    assign o_rf_rd_en   = i_rd_op & ~o_init;
    assign o_ibus_cyc   = ibus_cyc_q & ~i_rst;

    always_comb begin
        // NOTE: every next-state variable takes its held value first so no path leaves it unassigned (no latch).
        idx_d           = idx_q;
        cnt_en_d        = cnt_en_q;
        init_done_d     = init_done_q;
        jump_d          = jump_q;
        misalign_d      = misalign_q;
        ibus_cyc_d      = ibus_cyc_q;
        stage_two_req_d = cnt_done & o_init;

        if (!cnt_en_q) begin
            cnt_en_d = i_rf_ready;
            idx_d    = '0;
        end else if (cnt_done) begin
            cnt_en_d = 1'b0;
            idx_d    = '0;
        end else if (!stall_eff) begin
            idx_d = idx_q + 1'b1;
        end

        if (cnt_done) begin
            init_done_d = o_init & ~init_done_q;
            jump_d      = o_init & take_branch;
            misalign_d  = WITH_CSR & o_init & trap_pending;
        end

        // Ack and done together still produce one update from one expression.
        if (i_ibus_ack | cnt_done | i_rst)
            ibus_cyc_d = o_ctrl_pc_en | i_rst;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        ibus_cyc_q <= ibus_cyc_d;
        cnt_en_q   <= i_rst ? 1'b0 : cnt_en_d;
        // NOTE: with RESET_STRATEGY "NONE" the remaining state is left unreset; idle forces idx to 0 anyway.
        if (i_rst && RST_ALL) begin
            idx_q           <= '0;
            init_done_q     <= 1'b0;
            jump_q          <= 1'b0;
            misalign_q      <= 1'b0;
            stage_two_req_q <= 1'b0;
        end else begin
            idx_q           <= idx_d;
            init_done_q     <= init_done_d;
            jump_q          <= jump_d;
            misalign_q      <= misalign_d;
            stage_two_req_q <= stage_two_req_d;
        end
    end

endmodule

// File: tb/tb_serv_state_w.sv
// Directed bench for serv_state_w: W=1, W=4 and W=2-with-stall instances
// share decoder inputs; each has its own i_rf_ready so phases run one at a time.
module tb_serv_state_w;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic rst, new_irq, alu_cmp, stall, two_stage, branch_op, cond_branch, bne_or_bge;
    logic dbus_en, shift_op, sh_right, sh_done, slt_or_branch, e_op, rd_op, mdu_op;
    logic ctrl_misalign, mem_misalign, mdu_ready, dbus_ack, ibus_ack;
    logic rf1, rf4, rf2;

    logic       init1, en1, c0_1, c03_1, c12_1, done1, pc_en1, jump1, trap1;
    logic       mdu_v1, dbus_cyc1, ibus1, rreq1, wreq1, rd_en1;
    logic [4:0] cnt1;

    logic       en4, c0_4, c03_4, c12_4, done4;
    logic [4:0] cnt4;
    logic [9:0] m4;
    logic       en2, c0_2, c03_2, c12_2, done2;
    logic [4:0] cnt2;
    logic [9:0] m2;

    int n_cmp = 0;
    int n_bad = 0;

    serv_state_w #(.W(1), .RESET_STRATEGY("MINI"), .WITH_CSR(1'b1), .MDU(1'b0), .STALL(1'b0)) d1 (
        .i_clk(i_clk), .i_rst(rst), .i_new_irq(new_irq), .i_alu_cmp(alu_cmp), .i_stall(stall),
        .i_two_stage_op(two_stage), .i_branch_op(branch_op), .i_cond_branch(cond_branch),
        .i_bne_or_bge(bne_or_bge), .i_dbus_en(dbus_en), .i_shift_op(shift_op), .i_sh_right(sh_right),
        .i_sh_done(sh_done), .i_slt_or_branch(slt_or_branch), .i_e_op(e_op), .i_rd_op(rd_op),
        .i_mdu_op(mdu_op), .i_ctrl_misalign(ctrl_misalign), .i_mem_misalign(mem_misalign),
        .i_mdu_ready(mdu_ready), .i_dbus_ack(dbus_ack), .i_ibus_ack(ibus_ack), .i_rf_ready(rf1),
        .o_init(init1), .o_cnt_en(en1), .o_cnt(cnt1), .o_cnt0(c0_1), .o_cnt0to3(c03_1),
        .o_cnt12to31(c12_1), .o_cnt_done(done1), .o_ctrl_pc_en(pc_en1), .o_ctrl_jump(jump1),
        .o_ctrl_trap(trap1), .o_mdu_valid(mdu_v1), .o_dbus_cyc(dbus_cyc1), .o_ibus_cyc(ibus1),
        .o_rf_rreq(rreq1), .o_rf_wreq(wreq1), .o_rf_rd_en(rd_en1)
    );

    serv_state_w #(.W(4), .RESET_STRATEGY("MINI"), .WITH_CSR(1'b1), .MDU(1'b0), .STALL(1'b0)) d4 (
        .i_clk(i_clk), .i_rst(rst), .i_new_irq(new_irq), .i_alu_cmp(alu_cmp), .i_stall(stall),
        .i_two_stage_op(two_stage), .i_branch_op(branch_op), .i_cond_branch(cond_branch),
        .i_bne_or_bge(bne_or_bge), .i_dbus_en(dbus_en), .i_shift_op(shift_op), .i_sh_right(sh_right),
        .i_sh_done(sh_done), .i_slt_or_branch(slt_or_branch), .i_e_op(e_op), .i_rd_op(rd_op),
        .i_mdu_op(mdu_op), .i_ctrl_misalign(ctrl_misalign), .i_mem_misalign(mem_misalign),
        .i_mdu_ready(mdu_ready), .i_dbus_ack(dbus_ack), .i_ibus_ack(ibus_ack), .i_rf_ready(rf4),
        .o_init(m4[9]), .o_cnt_en(en4), .o_cnt(cnt4), .o_cnt0(c0_4), .o_cnt0to3(c03_4),
        .o_cnt12to31(c12_4), .o_cnt_done(done4), .o_ctrl_pc_en(m4[8]), .o_ctrl_jump(m4[7]),
        .o_ctrl_trap(m4[6]), .o_mdu_valid(m4[5]), .o_dbus_cyc(m4[4]), .o_ibus_cyc(m4[3]),
        .o_rf_rreq(m4[2]), .o_rf_wreq(m4[1]), .o_rf_rd_en(m4[0])
    );

    serv_state_w #(.W(2), .RESET_STRATEGY("MINI"), .WITH_CSR(1'b1), .MDU(1'b0), .STALL(1'b1)) d2 (
        .i_clk(i_clk), .i_rst(rst), .i_new_irq(new_irq), .i_alu_cmp(alu_cmp), .i_stall(stall),
        .i_two_stage_op(two_stage), .i_branch_op(branch_op), .i_cond_branch(cond_branch),
        .i_bne_or_bge(bne_or_bge), .i_dbus_en(dbus_en), .i_shift_op(shift_op), .i_sh_right(sh_right),
        .i_sh_done(sh_done), .i_slt_or_branch(slt_or_branch), .i_e_op(e_op), .i_rd_op(rd_op),
        .i_mdu_op(mdu_op), .i_ctrl_misalign(ctrl_misalign), .i_mem_misalign(mem_misalign),
        .i_mdu_ready(mdu_ready), .i_dbus_ack(dbus_ack), .i_ibus_ack(ibus_ack), .i_rf_ready(rf2),
        .o_init(m2[9]), .o_cnt_en(en2), .o_cnt(cnt2), .o_cnt0(c0_2), .o_cnt0to3(c03_2),
        .o_cnt12to31(c12_2), .o_cnt_done(done2), .o_ctrl_pc_en(m2[8]), .o_ctrl_jump(m2[7]),
        .o_ctrl_trap(m2[6]), .o_mdu_valid(m2[5]), .o_dbus_cyc(m2[4]), .o_ibus_cyc(m2[3]),
        .o_rf_rreq(m2[2]), .o_rf_wreq(m2[1]), .o_rf_rd_en(m2[0])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        {new_irq, alu_cmp, stall, two_stage, branch_op, cond_branch, bne_or_bge} = '0;
        {dbus_en, shift_op, sh_right, sh_done, slt_or_branch, e_op, rd_op, mdu_op} = '0;
        {ctrl_misalign, mem_misalign, mdu_ready, dbus_ack, ibus_ack, rf1, rf4, rf2} = '0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge i_clk);
        #1;
        check("rst_cnt_en", en1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_ibus_low", ibus1, 1'b0);
        rst = 1'b0;
        #1;
        check("rel_ibus_w1", ibus1, 1'b1);
        check("rel_misc_w4", m4, 10'b0000001000);
        check("rel_misc_w2", m2, 10'b0000001000);
        check("rel_cnt_w1", cnt1, 5'd0);
    endtask

    task automatic ibus_clear();
        @(negedge i_clk);
        ibus_ack = 1'b1;
        #1;
        check("ack_rreq", rreq1, 1'b1);
        @(negedge i_clk);
        ibus_ack = 1'b0;
        #1;
        check("ack_ibus_clr", ibus1, 1'b0);
    endtask

    // One full W=1 phase: 32 beats, each checked for count/flags and the init/pc_en split.
    task automatic phase1(input bit exp_init);
        logic [11:0] exp;
        @(negedge i_clk);
        rf1 = 1'b1;
        #1;
        check("w1_idle", en1, 1'b0);
        @(negedge i_clk);
        rf1 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge i_clk);
            #1;
            exp = {1'b1, 5'(k), k == 31, k == 0, k < 4, k >= 12, exp_init, !exp_init};
            check("w1_beat", {en1, cnt1, done1, c0_1, c03_1, c12_1, init1, pc_en1}, exp);
        end
        @(negedge i_clk);
        #1;
        check("w1_after", {en1, cnt1, done1}, 7'd0);
    endtask

    initial begin
        int idx_e, s5, s15;
        bit stall_now;
        rst = 1'b1;
        clear_inputs();

        // Reset, then a plain W=1 phase.
        do_reset();
        ibus_clear();
        phase1(1'b0);
        check("w1_ibus_after_done", ibus1, 1'b1);
        check("w1_wreq_idle", wreq1, 1'b0);

        // W=4: eight beats of 4 bits each.
        @(negedge i_clk);
        rf4 = 1'b1;
        @(negedge i_clk);
        rf4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge i_clk);
            #1;
            check("w4_beat", {en4, cnt4, done4, c0_4, c03_4, c12_4},
                  {1'b1, 5'(4 * k), k == 7, k == 0, k == 0, k >= 3});
        end
        @(negedge i_clk);
        #1;
        check("w4_after", {en4, cnt4, done4}, 7'd0);

        // W=2 with stall: 3 cycles at o_cnt=10, 2 cycles on the last beat.
        @(negedge i_clk);
        rf2 = 1'b1;
        @(negedge i_clk);
        rf2 = 1'b0;
        idx_e = 0;
        s5 = 0;
        s15 = 0;
        for (int t = 0; t < 40; t++) begin
            if (t > 0) @(negedge i_clk);
            stall_now = (idx_e == 5 && s5 < 3) || (idx_e == 15 && s15 < 2);
            stall = stall_now;
            #1;
            check("w2_stall_beat", {en2, cnt2, done2}, {1'b1, 5'(2 * idx_e), idx_e == 15 && !stall_now});
            if (stall_now) begin
                if (idx_e == 5) s5++;
                else s15++;
            end else if (idx_e == 15) begin
                break;
            end else begin
                idx_e++;
            end
        end
        stall = 1'b0;
        @(negedge i_clk);
        #1;
        check("w2_after", {en2, cnt2, done2}, 7'd0);

        // Two-stage taken BEQ.
        do_reset();
        ibus_clear();
        two_stage = 1'b1; branch_op = 1'b1; cond_branch = 1'b1; bne_or_bge = 1'b0;
        alu_cmp = 1'b1; rd_op = 1'b1;
        #1;
        check("beq_init", init1, 1'b1);
        check("beq_rd_en_init", rd_en1, 1'b0);
        phase1(1'b1);
        check("beq_jump", jump1, 1'b1);
        check("beq_init_low", init1, 1'b0);
        check("beq_rd_en", rd_en1, 1'b1);
        check("beq_ibus_held", ibus1, 1'b0);
        check("beq_trap", trap1, 1'b0);
        check("beq_rreq_aligned", rreq1, 1'b0);
        check("beq_wreq_none", wreq1, 1'b0);
        slt_or_branch = 1'b1;
        #1;
        check("beq_wreq", wreq1, 1'b1);
        slt_or_branch = 1'b0;
        phase1(1'b0);
        check("beq_ibus_fetch", ibus1, 1'b1);
        check("beq_jump_clr", jump1, 1'b0);
        check("beq_init_again", init1, 1'b1);

        // Not-taken BEQ: no jump.
        alu_cmp = 1'b0;
        phase1(1'b1);
        check("bnt_jump", jump1, 1'b0);

        // Misaligned load trap.
        do_reset();
        ibus_clear();
        two_stage = 1'b1; dbus_en = 1'b1; mem_misalign = 1'b1;
        phase1(1'b1);
        dbus_ack = 1'b1;
        #1;
        check("mis_rreq", rreq1, 1'b1);
        check("mis_trap", trap1, 1'b1);
        check("mis_dbus_cyc", dbus_cyc1, 1'b0);
        check("mis_wreq", wreq1, 1'b0);
        @(negedge i_clk);
        #1;
        check("mis_rreq_strobe", rreq1, 1'b0);
        check("mis_wreq_hold", wreq1, 1'b0);
        mem_misalign = 1'b0;
        dbus_ack = 1'b0;
        #1;
        check("aligned_dbus_cyc", dbus_cyc1, 1'b1);

        // Interrupt suppresses INIT and raises trap.
        do_reset();
        two_stage = 1'b1;
        new_irq = 1'b1;
        #1;
        check("irq_init", init1, 1'b0);
        check("irq_trap", trap1, 1'b1);

        // Reset in the middle of a phase.
        do_reset();
        ibus_clear();
        @(negedge i_clk);
        rf1 = 1'b1;
        @(negedge i_clk);
        rf1 = 1'b0;
        repeat (17) @(negedge i_clk);
        #1;
        check("mid_cnt17", cnt1, 5'd17);
        rst = 1'b1;
        #1;
        check("mid_ibus_rst", ibus1, 1'b0);
        @(negedge i_clk);
        #1;
        check("mid_idle", {en1, cnt1, done1}, 7'd0);
        rst = 1'b0;
        #1;
        check("mid_ibus_release", ibus1, 1'b1);
        @(negedge i_clk);
        #1;
        check("mid_no_done", {en1, done1}, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
